// File: rtl/vector_unpack_32.sv
// De-interleaves a 64-bit merged source into odd (S_OUT) and even (T_OUT) element vectors,
// one element per clock, under a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | routing element idx of the captured source into S_OUT/T_OUT
// DONE  | one-cycle done pulse, results valid
module vector_unpack_32 #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              MODE,
   input  logic [WORD_W-1:0] VY_hi,
   input  logic [WORD_W-1:0] VY_lo,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] S_OUT,
   output logic [WORD_W-1:0] T_OUT
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [2*WORD_W-1:0] src_q, src_d;
   logic                mode_q, mode_d;
   logic [WORD_W-1:0]   s_q, s_d, t_q, t_d;
   logic                last;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;

   assign byte_sel = src_q[{idx_q, 3'b000} +: 8];
   assign half_sel = src_q[{idx_q[1:0], 4'b0000} +: 16];
   assign last     = mode_q ? (idx_q == 3'd3) : (idx_q == 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         src_q   <= '0;
         mode_q  <= 1'b0;
         s_q     <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         mode_q  <= mode_d;
         s_q     <= s_d;
         t_q     <= t_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      src_d   = src_q;
      mode_d  = mode_q;
      s_d     = s_q;
      t_d     = t_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               src_d   = {VY_hi, VY_lo};
               mode_d  = MODE;
               idx_d   = '0;
               s_d     = '0;
               t_d     = '0;
            end
         end
         RUN: begin
            // odd elements go to S, even to T; lane is idx/2 in either mode
            if (mode_q) begin
               if (idx_q[0]) s_d[{idx_q[1], 4'b0000} +: 16] = half_sel;
               else          t_d[{idx_q[1], 4'b0000} +: 16] = half_sel;
            end else begin
               if (idx_q[0]) s_d[{idx_q[2:1], 3'b000} +: 8] = byte_sel;
               else          t_d[{idx_q[2:1], 3'b000} +: 8] = byte_sel;
            end
            if (last) state_d = DONE;
            else      idx_d   = idx_q + 3'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign S_OUT = s_q;
   assign T_OUT = t_q;

endmodule
